// File: rtl/osecpu_pkg.sv
// Shared widths and read-owner encoding for the OSECPU memory-side blocks.
package osecpu_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port synchronous memory.
// Data wins by default; fetch is forced through after STARVE_LIMIT data wins.
module mem_arbiter
    import osecpu_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
)
(
    input  logic              clk,
    input  logic              reset,

    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    owner_e     pending_q, pending_d;
    logic [2:0] starve_cnt_q, starve_cnt_d;
    logic       fetch_wins;

    always_comb begin
        // Grants are suppressed during reset so nothing reaches the memory.
        fetch_wins = f_req && (!d_req || (starve_cnt_q == 3'(STARVE_LIMIT)));
        f_gnt      = !reset && fetch_wins;
        d_gnt      = !reset && d_req && !fetch_wins;

        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (f_gnt) begin
            mem_addr = f_addr;
        end else if (d_gnt) begin
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            mem_we    = d_we;
        end

        pending_d = NONE;
        if (f_gnt) begin
            pending_d = FETCH;
        end else if (d_gnt && !d_we) begin
            pending_d = DATA;
        end

        starve_cnt_d = starve_cnt_q;
        if (!f_req || f_gnt) begin
            starve_cnt_d = '0;
        end else if (d_gnt) begin
            starve_cnt_d = starve_cnt_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q    <= NONE;
            starve_cnt_q <= '0;
        end else begin
            pending_q    <= pending_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Memory returns data one cycle after the address, so the registered
    // owner steers the shared read bus to the right port's valid.
    assign f_rvalid = (pending_q == FETCH);
    assign d_rvalid = (pending_q == DATA);
    assign f_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign busy     = f_gnt || d_gnt || (pending_q != NONE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a queue-based model
// of the arbitration and response rules, with a behavioural memory attached.
module tb_mem_arbiter;
    import osecpu_pkg::*;

    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              f_req, d_req, d_we;
    logic [ADDR_W-1:0] f_addr, d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              f_gnt, f_rvalid, d_gnt, d_rvalid, mem_we, busy;
    logic [DATA_W-1:0] f_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [ADDR_W-1:0] mem_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy)
    );

    logic [DATA_W-1:0] mem_array [0:65535];

    always @(posedge clk) begin
        if (mem_we) mem_array[mem_addr] <= mem_wdata;
        mem_rdata <= mem_array[mem_addr];
    end

    // Reference model: contents the memory should hold, number of data wins
    // fetch has sat through, and the in-order list of expected responses.
    typedef struct {
        logic              is_fetch;
        logic [DATA_W-1:0] data;
    } resp_t;

    logic [DATA_W-1:0] shadow [0:65535];
    int                starve;
    resp_t             resp_q[$];
    resp_t             resp_item;
    logic              exp_f_gnt, exp_d_gnt, obs_d_gnt;
    int                compared = 0;
    int                mismatched = 0;

    logic              rf, rd, rw;
    logic [ADDR_W-1:0] rfa, rda;
    logic [DATA_W-1:0] rwd;

    task automatic compare(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [ADDR_W-1:0] exp_addr;
        logic              exp_rv_f, exp_rv_d;
        exp_f_gnt = !reset && f_req && (!d_req || starve >= STARVE_LIMIT);
        exp_d_gnt = !reset && d_req && !exp_f_gnt;
        exp_addr  = exp_f_gnt ? f_addr : (exp_d_gnt ? d_addr : '0);
        exp_rv_f  = (resp_q.size() > 0) && resp_q[0].is_fetch;
        exp_rv_d  = (resp_q.size() > 0) && !resp_q[0].is_fetch;
        obs_d_gnt = d_gnt;

        compare({tag, ".f_gnt"}, 32'(f_gnt), 32'(exp_f_gnt));
        compare({tag, ".d_gnt"}, 32'(d_gnt), 32'(exp_d_gnt));
        compare({tag, ".mem_addr"}, 32'(mem_addr), 32'(exp_addr));
        compare({tag, ".mem_we"}, 32'(mem_we), 32'(exp_d_gnt && d_we));
        if (exp_d_gnt) compare({tag, ".mem_wdata"}, mem_wdata, d_wdata);
        else if (!exp_f_gnt) compare({tag, ".mem_wdata_idle"}, mem_wdata, '0);
        compare({tag, ".f_rvalid"}, 32'(f_rvalid), 32'(exp_rv_f));
        compare({tag, ".d_rvalid"}, 32'(d_rvalid), 32'(exp_rv_d));
        if (exp_rv_f) compare({tag, ".f_rdata"}, f_rdata, resp_q[0].data);
        if (exp_rv_d) compare({tag, ".d_rdata"}, d_rdata, resp_q[0].data);
        compare({tag, ".busy"}, 32'(busy), 32'(exp_f_gnt || exp_d_gnt || (resp_q.size() > 0)));
    endtask

    task automatic advanceModel();
        if (reset) return;
        if (resp_q.size() > 0) void'(resp_q.pop_front());
        if (exp_f_gnt) begin
            resp_item.is_fetch = 1'b1;
            resp_item.data     = shadow[f_addr];
            resp_q.push_back(resp_item);
        end else if (exp_d_gnt && !d_we) begin
            resp_item.is_fetch = 1'b0;
            resp_item.data     = shadow[d_addr];
            resp_q.push_back(resp_item);
        end else if (exp_d_gnt && d_we) begin
            shadow[d_addr] = d_wdata;
        end
        if (!f_req || exp_f_gnt) starve = 0;
        else if (exp_d_gnt) starve++;
    endtask

    task automatic applyStimulus(input logic fr, input logic [ADDR_W-1:0] fa,
                                 input logic dr, input logic dw, input logic [ADDR_W-1:0] da,
                                 input logic [DATA_W-1:0] wd, input string tag);
        f_req = fr; f_addr = fa; d_req = dr; d_we = dw; d_addr = da; d_wdata = wd;
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        advanceModel();
        #1;
    endtask

    task automatic modelReset();
        resp_q.delete();
        starve = 0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem_array[i] = {16'hA5A5, 16'(i)};
            shadow[i]    = {16'hA5A5, 16'(i)};
        end
        mem_array[16'h0010] = 32'hD3000000; shadow[16'h0010] = 32'hD3000000;
        mem_array[16'h0200] = 32'h12345678; shadow[16'h0200] = 32'h12345678;
        for (int i = 0; i < 8; i++) begin
            mem_array[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            shadow[i]    = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        end

        reset = 1'b1;
        modelReset();
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, "reset_idle");
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b1, 16'h0100, 32'hFFFF_FFFF, "reset_req");
        reset = 1'b0;

        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, "fetch_only");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, "fetch_only_resp");

        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, '0, "both_n");
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, '0, '0, "both_n1");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, "both_n2");

        applyStimulus(1'b0, '0, 1'b1, 1'b1, 16'h0100, 32'hCAFEBABE, "write");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'h0100, '0, "read_after_write");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, "raw_resp");

        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, '0, "starve");
            compare("starve_pattern", 32'(obs_d_gnt), 32'((i % 5) != 4));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, "starve_drain");

        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, '0, "pre_reset");
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, '0, "pre_reset");
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0003, '0, "read_then_reset");
        reset = 1'b1;
        modelReset();
        applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0003, '0, "in_reset");
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 16'h0010, 1'b1, 1'b0, 16'h0200, '0, "post_reset_starve");
            compare("post_reset_pattern", 32'(obs_d_gnt), 32'(i != 4));
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, "post_reset_drain");

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 16'(i), '0, "burst_read");
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, "burst_tail");
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, "burst_idle");

        rf = 1'b0; rd = 1'b0; rw = 1'b0; rfa = '0; rda = '0; rwd = '0;
        for (int c = 0; c < 400; c++) begin
            if (!rf && $urandom_range(0, 2) != 0) begin
                rf  = 1'b1;
                rfa = 16'($urandom_range(0, 15));
            end
            if (!rd && $urandom_range(0, 2) != 0) begin
                rd  = 1'b1;
                rw  = 1'($urandom_range(0, 1));
                rda = 16'($urandom_range(0, 15));
                rwd = $urandom;
            end
            applyStimulus(rf, rfa, rd, rw, rda, rwd, "random");
            if (exp_f_gnt) rf = 1'b0;
            if (exp_d_gnt) rd = 1'b0;
        end
        applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, "random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
